// File: rtl/inst_dispatch_if.sv
// ============================================================================
//  Module      : inst_dispatch_if
//  Description : Host word stream plus core issue bus (get_v/get_d/exec).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_dispatch_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        get_v;
    logic [15:0] get_d;
    logic        exec;

    // master: the dispatcher, which issues instructions to the core
    modport master (
        input  s_valid, s_data, s_last,
        output s_ready, get_v, get_d, exec
    );

    modport slave (
        output s_valid, s_data, s_last,
        input  s_ready, get_v, get_d, exec
    );
endinterface

`default_nettype wire

// File: rtl/inst_dispatch.sv
// ============================================================================
//  Module      : inst_dispatch
//  Description : Splits 32-bit host words into 16-bit instructions and issues
//                them one per cycle with exec framing; flushes after "last".
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_dispatch #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    inst_dispatch_if.master      bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err_no_last,
    output logic [CNT_W-1:0]     inst_count
);

    localparam logic [15:0] c_inject_op  = 16'h0400;
    localparam logic [5:0]  c_last_class = 6'b000001;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        TAIL  = 3'd2,
        DRAIN = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      r_state;
    logic [31:0] r_hold_word;
    logic        r_hold_vld;
    logic        r_hold_hi;
    logic        r_hold_last;
    logic        r_inject;
    logic        r_last_acc;
    logic        r_get_v;
    logic [15:0] r_get_d;
    logic        r_exec;

    logic [15:0]      w_half;
    logic             w_half_last;
    logic             w_run;
    logic             w_accept;
    logic             w_issue;
    logic             w_src_hi;
    logic [CNT_W-1:0] w_cnt_next;

    // With the holding register empty, the low half comes straight from the bus.
    assign w_half      = r_hold_vld ? (r_hold_hi ? r_hold_word[31:16] : r_hold_word[15:0])
                                    : bus.s_data[15:0];
    assign w_half_last = (w_half[15:10] == c_last_class);
    assign w_run       = (r_state == RUN);
    assign w_src_hi    = r_hold_vld & r_hold_hi;

    assign bus.s_ready = (w_run & ~r_inject &
                          (~r_hold_vld | (r_hold_hi & ~w_half_last & ~r_hold_last)))
                       | (r_state == FLUSH);
    assign w_accept    = bus.s_valid & bus.s_ready;
    assign w_issue     = w_run & (r_hold_vld | w_accept);
    assign w_cnt_next  = (&inst_count) ? inst_count : inst_count + CNT_W'(1);

    assign bus.get_v   = r_get_v;
    assign bus.get_d   = r_get_d;
    assign bus.exec    = r_exec;
    assign busy        = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold_word <= '0;
            r_hold_vld  <= 1'b0;
            r_hold_hi   <= 1'b0;
            r_hold_last <= 1'b0;
            r_inject    <= 1'b0;
            r_last_acc  <= 1'b0;
            r_get_v     <= 1'b0;
            r_get_d     <= '0;
            r_exec      <= 1'b0;
            done        <= 1'b0;
            err_no_last <= 1'b0;
            inst_count  <= '0;
        end else begin
            r_get_v <= 1'b0;
            r_get_d <= '0;
            done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_exec <= 1'b0;
                    if (start) begin
                        r_state     <= RUN;
                        inst_count  <= '0;
                        err_no_last <= 1'b0;
                        r_hold_vld  <= 1'b0;
                        r_hold_hi   <= 1'b0;
                        r_hold_last <= 1'b0;
                        r_inject    <= 1'b0;
                        r_last_acc  <= 1'b0;
                    end
                end
                RUN: begin
                    // exec rises after the first issue and holds through input bubbles
                    r_exec <= r_exec | r_get_v;
                    if (w_accept && bus.s_last) begin
                        r_last_acc <= 1'b1;
                    end
                    if (r_inject) begin
                        r_get_v     <= 1'b1;
                        r_get_d     <= c_inject_op;
                        inst_count  <= w_cnt_next;
                        err_no_last <= 1'b1;
                        r_inject    <= 1'b0;
                        r_state     <= TAIL;
                    end else if (w_issue) begin
                        r_get_v    <= 1'b1;
                        r_get_d    <= w_half;
                        inst_count <= w_cnt_next;
                        if (w_half_last) begin
                            r_hold_vld <= 1'b0;
                            r_state    <= TAIL;
                        end else if (!w_src_hi) begin
                            if (!r_hold_vld) begin
                                r_hold_word <= bus.s_data;
                                r_hold_last <= bus.s_last;
                            end
                            r_hold_vld <= 1'b1;
                            r_hold_hi  <= 1'b1;
                        end else if (r_hold_last) begin
                            r_hold_vld <= 1'b0;
                            r_inject   <= 1'b1;
                        end else if (w_accept) begin
                            // next word lands while its predecessor's high half issues
                            r_hold_word <= bus.s_data;
                            r_hold_last <= bus.s_last;
                            r_hold_vld  <= 1'b1;
                            r_hold_hi   <= 1'b0;
                        end else begin
                            r_hold_vld <= 1'b0;
                        end
                    end
                end
                TAIL: begin
                    r_exec  <= 1'b1;
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    r_exec <= 1'b0;
                    if (r_last_acc) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_exec <= 1'b0;
                    if (bus.s_valid && bus.s_last) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    r_exec  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_dispatch.sv
// ============================================================================
//  Module      : tb_inst_dispatch
//  Description : Directed program runs checked every cycle against an
//                instruction-list and exec-window model of the dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        err_no_last;
    logic [15:0] inst_count;

    inst_dispatch_if bus ();

    inst_dispatch #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err_no_last (err_no_last),
        .inst_count  (inst_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: expected instruction list (bit 16 marks the injected last) and exec window
    logic [16:0] exp_q[$];
    logic [15:0] seen_q[$];
    int  gv_count, done_cnt, run_cur, run_max, low_cur, low_max, exec_cycles;
    bit  started, last_prev, last_old, exp_err, mon_en;

    logic [31:0] wq[$];
    bit          lq[$];
    int          gq[$];

    function automatic bit is_last_op(input logic [15:0] d);
        return d[15:10] == 6'b000001;
    endfunction

    function automatic logic [15:0] seen_at(input int i);
        if (i < seen_q.size()) return seen_q[i];
        return 16'hDEAD;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        seen_q.delete();
        gv_count = 0; done_cnt = 0; run_cur = 0; run_max = 0;
        low_cur = 0; low_max = 0; exec_cycles = 0;
        started = 0; last_prev = 0; last_old = 0; exp_err = 0;
    endtask

    task automatic load_model();
        bit ended = 0;
        logic [31:0] w;
        logic [15:0] half;
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            for (int h = 0; h < 2; h++) begin
                if (!ended) begin
                    half = (h == 0) ? w[15:0] : w[31:16];
                    exp_q.push_back({1'b0, half});
                    if (is_last_op(half)) ended = 1;
                end
            end
            if (lq[i] && !ended) begin
                exp_q.push_back({1'b1, 16'h0400});
                ended = 1;
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [16:0] e;
        bit exp_exec;
        if (mon_en) begin
            exp_exec = started && !last_old;
            check("exec", {31'b0, bus.exec}, {31'b0, exp_exec});
            if (bus.get_v) begin
                if (exp_q.size() == 0) begin
                    check("get_v_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("get_d", {16'b0, bus.get_d}, {16'b0, e[15:0]});
                    if (e[16]) exp_err = 1;
                end
                if (gv_count < 65535) gv_count++;
                seen_q.push_back(bus.get_d);
                run_cur++;
                if (run_cur > run_max) run_max = run_cur;
                if (low_cur > low_max) low_max = low_cur;
                low_cur = 0;
            end else begin
                check("get_d_idle", {16'b0, bus.get_d}, 32'd0);
                run_cur = 0;
                if (started && !last_prev && !last_old) low_cur++;
            end
            check("inst_count", {16'b0, inst_count}, gv_count);
            check("err_no_last", {31'b0, err_no_last}, {31'b0, exp_err});
            if (!busy) check("s_ready_idle", {31'b0, bus.s_ready}, 32'd0);
            if (done) begin
                done_cnt++;
                check("done_context", {31'b0, (exp_q.size() == 0) && last_old}, 32'd1);
            end
            if (bus.exec) exec_cycles++;
            last_old  = last_old | last_prev;
            last_prev = bus.get_v && is_last_op(bus.get_d);
            started   = started | bus.get_v;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_word(input logic [31:0] w, input bit l);
        bit acc;
        int budget = 100;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        bus.s_last  = l;
        while (1) begin
            #1;
            acc = bus.s_ready;
            @(negedge clk);
            #2;
            if (acc) break;
            budget--;
            if (budget == 0) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
    endtask

    task automatic run_prog(input bit poke_start);
        int budget = 200;
        model_reset();
        load_model();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < wq.size(); i++) begin
            repeat (gq[i]) step();
            push_word(wq[i], lq[i]);
            if (poke_start && i == 0) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
        end
        while (done_cnt == 0 && budget > 0) begin
            step();
            budget--;
        end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        step();
        step();
        check("done_pulses", done_cnt, 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        mon_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        step();
        mon_en = 1'b1;
        step();
        check("rst_get_v",   {31'b0, bus.get_v},   32'd0);
        check("rst_exec",    {31'b0, bus.exec},    32'd0);
        check("rst_s_ready", {31'b0, bus.s_ready}, 32'd0);
        check("rst_busy",    {31'b0, busy},        32'd0);
        check("rst_count",   {16'b0, inst_count},  32'd0);
        rst = 1'b0;
        repeat (2) step();

        // single word with last in high half
        wq = '{32'h0400_8005}; lq = '{1'b1}; gq = '{0};
        run_prog(1'b0);
        check("t1_len", seen_q.size(), 32'd2);
        check("t1_d0", {16'b0, seen_at(0)}, 32'h8005);
        check("t1_d1", {16'b0, seen_at(1)}, 32'h0400);
        check("t1_count", {16'b0, inst_count}, 32'd2);
        check("t1_exec_cycles", exec_cycles, 32'd2);

        // back-to-back words
        wq = '{32'h2222_1111, 32'h4444_3333, 32'h0401_5555}; lq = '{1'b0, 1'b0, 1'b1}; gq = '{0, 0, 0};
        run_prog(1'b0);
        check("t2_run", run_max, 32'd6);
        check("t2_gap", low_max, 32'd0);
        check("t2_count", {16'b0, inst_count}, 32'd6);

        // last in low half of first word, rest flushed
        wq = '{32'h7777_0401, 32'h8888_9999, 32'hAAAA_BBBB}; lq = '{1'b0, 1'b0, 1'b1}; gq = '{0, 0, 0};
        run_prog(1'b0);
        check("t3_len", seen_q.size(), 32'd1);
        check("t3_d0", {16'b0, seen_at(0)}, 32'h0401);
        check("t3_count", {16'b0, inst_count}, 32'd1);

        // stream ends without a last opcode
        wq = '{32'h0000_8400}; lq = '{1'b1}; gq = '{0};
        run_prog(1'b0);
        check("t4_d0", {16'b0, seen_at(0)}, 32'h8400);
        check("t4_d1", {16'b0, seen_at(1)}, 32'h0000);
        check("t4_d2", {16'b0, seen_at(2)}, 32'h0400);
        check("t4_err", {31'b0, err_no_last}, 32'd1);
        check("t4_count", {16'b0, inst_count}, 32'd3);
        repeat (3) step();
        check("t4_err_sticky", {31'b0, err_no_last}, 32'd1);

        // 4-cycle s_valid gap between words
        wq = '{32'h0002_0001, 32'h0401_0003}; lq = '{1'b0, 1'b1}; gq = '{0, 4};
        run_prog(1'b0);
        check("t5_err_cleared", {31'b0, err_no_last}, 32'd0);
        check("t5_low", low_max, 32'd3);
        check("t5_exec_cycles", exec_cycles, 32'd7);
        check("t5_count", {16'b0, inst_count}, 32'd4);

        // reset two cycles into RUN aborts
        wq = '{32'h1111_2222}; lq = '{1'b0}; gq = '{0};
        model_reset();
        load_model();
        start = 1'b1;
        step();
        start = 1'b0;
        push_word(32'h1111_2222, 1'b0);
        step();
        rst = 1'b1;
        model_reset();
        step();
        check("abort_busy",    {31'b0, busy},        32'd0);
        check("abort_get_v",   {31'b0, bus.get_v},   32'd0);
        check("abort_exec",    {31'b0, bus.exec},    32'd0);
        check("abort_s_ready", {31'b0, bus.s_ready}, 32'd0);
        rst = 1'b0;
        repeat (3) step();
        check("abort_no_done", done_cnt, 32'd0);

        // clean rerun, then start pulsed while busy
        wq = '{32'h0400_8005}; lq = '{1'b1}; gq = '{0};
        run_prog(1'b0);
        check("t6_rerun_count", {16'b0, inst_count}, 32'd2);
        wq = '{32'h2222_1111, 32'h0401_3333}; lq = '{1'b0, 1'b1}; gq = '{0, 1};
        run_prog(1'b1);
        check("t6_busy_start_count", {16'b0, inst_count}, 32'd4);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
